// File: rtl/eda_task_fifo_reader_pkg.sv
// eda_task_fifo_reader_pkg: state encoding and line levels shared by the
// FIFO reader / serialiser. EDA_TASK_FIFO_READER_PARITY_EN inserts a PARITY
// state between DATA and STOP.
`timescale 1ns/1ps
package eda_task_fifo_reader_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] S_POP    = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD   = 3'd2;
  localparam logic [STATE_W-1:0] S_START  = 3'd3;
  localparam logic [STATE_W-1:0] S_DATA   = 3'd4;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
  localparam logic [STATE_W-1:0] S_PARITY = 3'd5;
  localparam logic [STATE_W-1:0] S_STOP   = 3'd6;
`else
  localparam logic [STATE_W-1:0] S_STOP   = 3'd5;
`endif

  localparam logic TX_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/eda_task_fifo_reader_if.sv
// eda_task_fifo_reader_if: FIFO read port seen by the reader.
// Handshake: EMPTY=0 means a byte is available; RD_EN is a one-cycle pop
// request, and FIFO_OUT holds the popped byte from the edge that samples
// RD_EN high until the next pop.
`timescale 1ns/1ps
interface eda_task_fifo_reader_if #(parameter int DATA_W = 8);
  logic              RD_EN;
  logic [DATA_W-1:0] FIFO_OUT;
  logic              EMPTY;

  modport master (output RD_EN, input FIFO_OUT, input EMPTY);
  modport slave  (input RD_EN, output FIFO_OUT, output EMPTY);
endinterface

// File: rtl/eda_task_baud_tick.sv
// eda_task_baud_tick: counts CLKS_PER_BIT cycles per serial bit and flags the
// last cycle of each bit. Held at zero while clr is high so every bit of a
// frame starts from a fresh count.
`timescale 1ns/1ps
module eda_task_baud_tick
  import eda_task_fifo_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running 0..CLKS_PER_BIT-1 count while the FSM is inside a frame
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/eda_task_fifo_reader.sv
// eda_task_fifo_reader: pops bytes from the FIFO read port and sends each as
// a start/data(LSB first)/stop frame on TX. Define
// EDA_TASK_FIFO_READER_PARITY_EN to add an even-parity bit before STOP.
// dbg_state exposes the FSM state register.
`timescale 1ns/1ps
module eda_task_fifo_reader
  import eda_task_fifo_reader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic                   SYSCLK,
  input  logic                   RST,
  input  logic                   ENABLE,
  eda_task_fifo_reader_if.master fifo,
  output logic                   TX,
  output logic                   BUSY,
  output logic                   TX_DONE,
  output logic [STATE_W-1:0]     dbg_state
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  logic [STATE_W-1:0] state;
  logic [DATA_W-1:0]  shreg;
  logic [BIT_W-1:0]   bit_cnt;
  logic               baud_clr;
  logic               baud_tick;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
  logic               parity;
`endif

  // The baud counter only runs while a bit is on the line
  assign baud_clr  = (state == S_IDLE) || (state == S_POP) || (state == S_LOAD);
  assign dbg_state = state;

  eda_task_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (SYSCLK),
    .rst  (RST),
    .clr  (baud_clr),
    .tick (baud_tick)
  );

  // Frame FSM: pop, load, then shift bits out with all outputs registered
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state      <= S_IDLE;
      fifo.RD_EN <= 1'b0;
      TX         <= TX_IDLE;
      BUSY       <= 1'b0;
      TX_DONE    <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      TX_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ENABLE && !fifo.EMPTY) begin
            state      <= S_POP;
            fifo.RD_EN <= 1'b1;
            BUSY       <= 1'b1;
          end
        end
        S_POP: begin
          // The FIFO sees the pop at this edge; its data is valid next cycle
          fifo.RD_EN <= 1'b0;
          state      <= S_LOAD;
        end
        S_LOAD: begin
          shreg <= fifo.FIFO_OUT;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
          parity <= ^fifo.FIFO_OUT;
`endif
          TX    <= START_BIT;
          state <= S_START;
        end
        S_START: begin
          if (baud_tick) begin
            TX      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
              TX    <= parity;
              state <= S_PARITY;
`else
              TX    <= STOP_BIT;
              state <= S_STOP;
`endif
            end else begin
              TX      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
        S_PARITY: begin
          if (baud_tick) begin
            TX    <= STOP_BIT;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_tick) begin
            TX      <= TX_IDLE;
            BUSY    <= 1'b0;
            TX_DONE <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          fifo.RD_EN <= 1'b0;
          TX         <= TX_IDLE;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eda_task_fifo_reader.sv
// tb_eda_task_fifo_reader: directed bench for the FIFO reader / serialiser
// with a queue-backed FIFO model on the read port.
`timescale 1ns/1ps
module tb_eda_task_fifo_reader;

  localparam int CPB    = 4;
  localparam int DATA_W = 8;
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  // clock / reset
  logic clk;
  logic rst;
  logic enable;
  logic tx;
  logic busy;
  logic tx_done;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  eda_task_fifo_reader_if #(.DATA_W(DATA_W)) fifo_if ();

  eda_task_fifo_reader #(.CLKS_PER_BIT(CPB), .DATA_W(DATA_W)) dut (
    .SYSCLK    (clk),
    .RST       (rst),
    .ENABLE    (enable),
    .fifo      (fifo_if),
    .TX        (tx),
    .BUSY      (busy),
    .TX_DONE   (tx_done),
    .dbg_state (dbg_state)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // FIFO model: pop on a sampled RD_EN, data valid after that edge
  logic [DATA_W-1:0] fifo_q[$];
  always @(posedge clk) begin
    if (fifo_if.RD_EN === 1'b1 && fifo_q.size() != 0) fifo_if.FIFO_OUT <= fifo_q.pop_front();
    fifo_if.EMPTY <= (fifo_q.size() == 0);
  end

  // scoreboard of bytes expected on the line
  logic [DATA_W-1:0] exp_q[$];

  // monitor: pulse counts and RD_EN legality (single cycle, only from idle)
  int   rd_cnt = 0;
  int   done_cnt = 0;
  int   rd_viol = 0;
  logic prev_busy = 1'b0;
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    if (fifo_if.RD_EN === 1'b1) begin
      rd_cnt++;
      if (prev_busy !== 1'b0 || prev_rd !== 1'b0) rd_viol++;
    end
    if (tx_done === 1'b1) done_cnt++;
    prev_busy = busy;
    prev_rd   = fifo_if.RD_EN;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_W-1:0] b);
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
    frame_of = {1'b1, ^b, b, 1'b0};
`else
    frame_of = {1'b1, b, 1'b0};
`endif
  endfunction

  // Capture one frame: waits for the start bit, samples every bit cycle and
  // finds the TX_DONE cycle relative to the fall of TX. No checking here.
  task automatic capture_frame(output logic [FRAME_BITS-1:0] bits, output logic stable,
                               output int done_at, output int wait_hi, output logic timed_out);
    int n;
    bits = '0; stable = 1'b1; done_at = -1; wait_hi = 0; timed_out = 1'b0; n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 300) begin
      if (tx === 1'b1) wait_hi++;
      n++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    for (int k = 0; k <= FRAME_CYC; k++) begin
      if (k > 0) @(negedge clk);
      if (k < FRAME_CYC) begin
        if (k % CPB == 0) bits[k / CPB] = tx;
        else if (tx !== bits[k / CPB]) stable = 1'b0;
      end
      if (tx_done === 1'b1 && done_at < 0) done_at = k;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0;
    repeat (2) @(negedge clk);
    assert_cnt++;
    if ({tx, fifo_if.RD_EN, busy, tx_done} !== 4'b1000) begin
      fail_cnt++; $display("FAIL reset_outputs: got %b expected 1000", {tx, fifo_if.RD_EN, busy, tx_done});
    end
    assert_cnt++;
    if (dbg_state !== 3'd0) begin
      fail_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
    rst = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      assert_cnt++;
      if ({tx, fifo_if.RD_EN, busy, tx_done} !== 4'b1000) begin
        fail_cnt++; $display("FAIL post_reset_idle[%0d]: got %b expected 1000", i, {tx, fifo_if.RD_EN, busy, tx_done});
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [FRAME_BITS-1:0] bits;
    logic stable, to;
    int done_at, wait_hi, rd0, d0;
    rd0 = rd_cnt; d0 = done_cnt;
    enable = 1'b1;
    fifo_q.push_back(8'hA5);
    capture_frame(bits, stable, done_at, wait_hi, to);
    @(negedge clk);
    assert_cnt++;
    if (to !== 1'b0) begin fail_cnt++; $display("FAIL single_timeout: got %b expected 0", to); end
    assert_cnt++;
    if (bits !== frame_of(8'hA5)) begin
      fail_cnt++; $display("FAIL single_bits: got %b expected %b", bits, frame_of(8'hA5));
    end
`ifndef EDA_TASK_FIFO_READER_PARITY_EN
    assert_cnt++;
    if (bits !== 10'b1101001010) begin
      fail_cnt++; $display("FAIL single_bits_hand: got %b expected 1101001010", bits);
    end
`endif
    assert_cnt++;
    if (stable !== 1'b1) begin fail_cnt++; $display("FAIL single_bit_hold: got %b expected 1", stable); end
    assert_cnt++;
    if (done_at != FRAME_CYC) begin fail_cnt++; $display("FAIL single_done_at: got %0d expected %0d", done_at, FRAME_CYC); end
    assert_cnt++;
    if (rd_cnt - rd0 != 1) begin fail_cnt++; $display("FAIL single_rd_pulses: got %0d expected 1", rd_cnt - rd0); end
    assert_cnt++;
    if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_empty_idle();
    int bad, rd0;
    bad = 0; rd0 = rd_cnt;
    enable = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_if.RD_EN !== 1'b0 || busy !== 1'b0) bad++;
    end
    assert_cnt++;
    if (bad != 0) begin fail_cnt++; $display("FAIL empty_idle_cycles: got %0d bad cycles expected 0", bad); end
    assert_cnt++;
    if (rd_cnt != rd0) begin fail_cnt++; $display("FAIL empty_rd_pulses: got %0d expected 0", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [FRAME_BITS-1:0] bits;
    logic [DATA_W-1:0] exp_b;
    logic stable, to;
    int done_at, wait_hi, rd0, d0;
    rd0 = rd_cnt; d0 = done_cnt;
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      fifo_q.push_back(DATA_W'(i));
      exp_q.push_back(DATA_W'(i));
    end
    for (int f = 0; f < 3; f++) begin
      capture_frame(bits, stable, done_at, wait_hi, to);
      exp_b = exp_q.pop_front();
      assert_cnt++;
      if (to !== 1'b0 || bits !== frame_of(exp_b) || stable !== 1'b1) begin
        fail_cnt++; $display("FAIL b2b_frame[%0d]: got %b expected %b (timeout %b)", f, bits, frame_of(exp_b), to);
      end
      assert_cnt++;
      if (done_at != FRAME_CYC) begin fail_cnt++; $display("FAIL b2b_done_at[%0d]: got %0d expected %0d", f, done_at, FRAME_CYC); end
      if (f > 0) begin
        // the TX_DONE cycle plus wait_hi cycles form the idle gap
        assert_cnt++;
        if (wait_hi + 1 != 3) begin fail_cnt++; $display("FAIL b2b_gap[%0d]: got %0d expected 3", f, wait_hi + 1); end
      end
    end
    repeat (20) @(negedge clk);
    assert_cnt++;
    if (rd_cnt - rd0 != 3) begin fail_cnt++; $display("FAIL b2b_rd_pulses: got %0d expected 3", rd_cnt - rd0); end
    assert_cnt++;
    if (done_cnt - d0 != 3) begin fail_cnt++; $display("FAIL b2b_done_pulses: got %0d expected 3", done_cnt - d0); end
    assert_cnt++;
    if (busy !== 1'b0) begin fail_cnt++; $display("FAIL b2b_idle_after: got %b expected 0", busy); end
  endtask

  task automatic test_enable_drop();
    logic [FRAME_BITS-1:0] bits;
    logic stable, to;
    int done_at, wait_hi, rd0, n;
    rd0 = rd_cnt; n = 0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC6);
    enable = 1'b1;
    @(negedge clk);
    while (busy !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    enable = 1'b0;
    capture_frame(bits, stable, done_at, wait_hi, to);
    assert_cnt++;
    if (to !== 1'b0 || bits !== frame_of(8'h3C) || done_at != FRAME_CYC) begin
      fail_cnt++; $display("FAIL drop_frame: got %b done %0d expected %b done %0d", bits, done_at, frame_of(8'h3C), FRAME_CYC);
    end
    repeat (30) @(negedge clk);
    assert_cnt++;
    if (rd_cnt - rd0 != 1 || busy !== 1'b0) begin
      fail_cnt++; $display("FAIL drop_stays_idle: got %0d pops busy %b expected 1 pops busy 0", rd_cnt - rd0, busy);
    end
    enable = 1'b1;
    capture_frame(bits, stable, done_at, wait_hi, to);
    assert_cnt++;
    if (to !== 1'b0 || bits !== frame_of(8'hC6)) begin
      fail_cnt++; $display("FAIL drop_resume_frame: got %b expected %b", bits, frame_of(8'hC6));
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [FRAME_BITS-1:0] bits;
    logic stable, to;
    int done_at, wait_hi, rd0, d0, n;
    rd0 = rd_cnt; d0 = done_cnt; n = 0;
    enable = 1'b1;
    fifo_q.push_back(8'hC3);
    @(negedge clk);
    while (tx !== 1'b0 && n < 100) begin n++; @(negedge clk); end
    assert_cnt++;
    if (tx !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_start_timeout: got tx %b expected 0", tx); end
    // data bit 3 spans cycles 16..19 after the fall of TX
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    assert_cnt++;
    if ({tx, fifo_if.RD_EN, busy, tx_done} !== 4'b1000) begin
      fail_cnt++; $display("FAIL rstmid_outputs: got %b expected 1000", {tx, fifo_if.RD_EN, busy, tx_done});
    end
    rst = 1'b0;
    fifo_q.push_back(8'h5A);
    capture_frame(bits, stable, done_at, wait_hi, to);
    @(negedge clk);
    assert_cnt++;
    if (to !== 1'b0 || bits !== frame_of(8'h5A) || done_at != FRAME_CYC) begin
      fail_cnt++; $display("FAIL rstmid_fresh_frame: got %b done %0d expected %b done %0d", bits, done_at, frame_of(8'h5A), FRAME_CYC);
    end
    assert_cnt++;
    if (rd_cnt - rd0 != 2) begin fail_cnt++; $display("FAIL rstmid_rd_pulses: got %0d expected 2", rd_cnt - rd0); end
    assert_cnt++;
    if (done_cnt - d0 != 1) begin fail_cnt++; $display("FAIL rstmid_done_pulses: got %0d expected 1", done_cnt - d0); end
  endtask

`ifdef EDA_TASK_FIFO_READER_PARITY_EN
  task automatic test_parity();
    logic [FRAME_BITS-1:0] bits;
    logic stable, to;
    int done_at, wait_hi;
    enable = 1'b1;
    fifo_q.push_back(8'h07);
    capture_frame(bits, stable, done_at, wait_hi, to);
    assert_cnt++;
    if (to !== 1'b0 || bits !== 11'b11000001110) begin
      fail_cnt++; $display("FAIL parity_frame: got %b expected 11000001110", bits);
    end
    assert_cnt++;
    if (done_at != 44) begin fail_cnt++; $display("FAIL parity_frame_len: got %0d expected 44", done_at); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    test_reset();
    test_single_frame();
    test_empty_idle();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();
`ifdef EDA_TASK_FIFO_READER_PARITY_EN
    test_parity();
`endif
    assert_cnt++;
    if (rd_viol != 0) begin fail_cnt++; $display("FAIL rd_en_legality: got %0d violations expected 0", rd_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/eda_task_fifo_reader.md
Name: eda_task_fifo_reader

Overview:
Read-side consumer for the team's 8-bit FIFO. It pops one byte at a time from the FIFO read port (RD_EN / FIFO_OUT / EMPTY) and serialises each byte as an asynchronous UART-style frame on TX. It sits downstream of the FIFO and drains it whenever enabled and data is present.

Parameters:
CLKS_PER_BIT, 4, SYSCLK cycles per serial bit (min 2)
DATA_W, 8, byte width; must match the FIFO data width

Ports:
SYSCLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
ENABLE  input  1  1 = allowed to start a new pop/frame
EMPTY  input  1  FIFO empty flag
FIFO_OUT  input  DATA_W  FIFO read data; valid after the edge at which RD_EN is sampled high
RD_EN  output  1  FIFO pop request; registered; single-cycle pulse per byte
TX  output  1  serial line; idles high
BUSY  output  1  high whenever state != IDLE
TX_DONE  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Clock and reset: one clock, SYSCLK. RST is synchronous and active-high.
- Reset values (edge with RST=1): state IDLE; RD_EN=0, TX=1, BUSY=0, TX_DONE=0; bit and baud counters 0; shift register 0.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE:
  - At edge E0, if ENABLE=1 and EMPTY=0: go to POP and drive RD_EN=1 for the following cycle.
  - Otherwise remain in IDLE.
- POP: at the next edge E1, set RD_EN=0 and go to LOAD. The FIFO samples the pop at E1.
- LOAD: at edge E2, latch FIFO_OUT into the shift register, drive TX=0 and go to START.
- START, DATA, PARITY, STOP: each bit is held for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1.
  - DATA: DATA_W bits, LSB first.
  - STOP: TX=1.
- End of STOP: at the final STOP edge, go to IDLE and pulse TX_DONE=1 for one cycle.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles of TX activity, measured from the fall of TX to the end of STOP.
- Back-to-back frames: with data still available, TX stays high for exactly 3 cycles (IDLE, POP, LOAD) between the end of STOP and the next start bit.
- RD_EN rules:
  - RD_EN is never asserted in a cycle that follows an IDLE edge where EMPTY=1.
  - Exactly one RD_EN pulse per frame.
  - No RD_EN while BUSY is high, except the POP cycle itself.
- ENABLE dropped mid-frame: the current frame completes normally; the block then stays in IDLE.
- EMPTY changes outside IDLE are ignored.
- RST mid-frame:
  - At the reset edge: TX=1, RD_EN=0, no TX_DONE.
  - The byte already popped is discarded and is not re-sent.
- RST in POP: RD_EN drops at that edge. The FIFO-side pop still occurs if the FIFO saw RD_EN; accepted loss.
- Counter widths: baud counter $clog2(CLKS_PER_BIT); bit counter $clog2(DATA_W+1). Both wrap only under FSM control.

Optional Feature:
EDA_TASK_FIFO_READER_PARITY_EN
- Defined: a PARITY state between DATA and STOP transmits the even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles. Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, DATA goes directly to STOP.

Decomposition:
- Package eda_task_fifo_reader_pkg:
  - state encoding localparams (IDLE=0 .. STOP)
  - TX_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- Sub-module eda_task_baud_tick:
  - CLKS_PER_BIT counter with a clear input
  - one-cycle tick output on the last cycle of each bit
  - used by the FSM for bit advance

Test Plan:
1. RST=1 for 2 cycles, then released with EMPTY=1 → TX=1, RD_EN=0, BUSY=0, TX_DONE=0 throughout.
2. ENABLE=1, EMPTY=0 once, FIFO_OUT=8'hA5, CLKS_PER_BIT=4 → one RD_EN pulse; TX = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; TX_DONE pulses 40 cycles after TX falls.
3. ENABLE=1, EMPTY=1 held for 100 cycles → RD_EN never 1, TX stays 1.
4. FIFO preloaded with 8'h01, 8'h02, 8'h03 → three RD_EN pulses, three frames carrying those values, exactly 3 high cycles between each stop bit and the next start bit, three TX_DONE pulses; EMPTY then holds the block in IDLE.
5. RST asserted during DATA bit 3 → TX=1 and BUSY=0 at the next edge, no TX_DONE; after release with EMPTY=0, a fresh frame starts with a new pop.
6. With PARITY_EN defined, FIFO_OUT=8'h07 → parity bit 1 after the data bits; frame is 44 cycles at CLKS_PER_BIT=4.
